// File: rtl/sad_trigger_ctrl_if.sv
// -----------------------------------------------------------------------------
// sad_trigger_ctrl_if
//   Groups the control, match and status signals of the SAD trigger sequencer.
//
//   Controller-facing inputs (driven by the master side):
//     armed_and_ready    capture armed (level)
//     short_sad          use half-length reference (sampled when arming)
//     multiple_triggers  re-trigger after holdoff when set
//     holdoff            post-trigger dead time in clk_adc cycles
//     clear_status       single-cycle pulse clearing triggered / num_triggers
//     match_in           raw "SAD <= threshold" from the datapath
//   Status outputs (driven by the slave side, i.e. the controller):
//     sad_flush          holds the SAD datapath pipeline in flush
//     trigger            qualified trigger, one cycle wide
//     triggered          sticky "at least one trigger since clear"
//     num_triggers       saturating trigger count
//     state              FSM state for debug readback
// -----------------------------------------------------------------------------
interface sad_trigger_ctrl_if #(
  parameter int pCOUNT_WIDTH   = 8,
  parameter int pHOLDOFF_WIDTH = 16
);
  logic                      armed_and_ready;
  logic                      short_sad;
  logic                      multiple_triggers;
  logic [pHOLDOFF_WIDTH-1:0] holdoff;
  logic                      clear_status;
  logic                      match_in;

  logic                      sad_flush;
  logic                      trigger;
  logic                      triggered;
  logic [pCOUNT_WIDTH-1:0]   num_triggers;
  logic [2:0]                state;

  // Register block / datapath side: drives control and match, reads status.
  modport master (
    output armed_and_ready, short_sad, multiple_triggers, holdoff,
           clear_status, match_in,
    input  sad_flush, trigger, triggered, num_triggers, state
  );

  // Sequencer side.
  modport slave (
    input  armed_and_ready, short_sad, multiple_triggers, holdoff,
           clear_status, match_in,
    output sad_flush, trigger, triggered, num_triggers, state
  );
endinterface

// File: rtl/sad_trigger_ctrl.sv
// -----------------------------------------------------------------------------
// sad_trigger_ctrl
//   Sequencing controller for the SAD trigger datapath (clk_adc domain).
//   Turns the raw per-sample SAD match into a qualified, one-cycle trigger:
//   keeps the datapath in flush while disarmed, waits for the reference
//   buffer to fill after arming, enforces a holdoff between triggers in
//   multiple-trigger mode and keeps the sticky flag / saturating count that
//   software reads back through the SAD status register.
//
//   Ports:
//     clk_adc   ADC sample clock (only clock)
//     reset_n   asynchronous active-low reset
//     bus       sad_trigger_ctrl_if.slave (control inputs, status outputs)
//
//   Every output is a flop or a decode of the state flop; there is no
//   combinational path from any input to any output.
// -----------------------------------------------------------------------------
module sad_trigger_ctrl #(
  parameter int pREF_SAMPLES   = 128,
  parameter int pCOUNT_WIDTH   = 8,
  parameter int pHOLDOFF_WIDTH = 16
) (
  input  logic                 clk_adc,
  input  logic                 reset_n,
  sad_trigger_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    ACTIVE  = 3'd2,
    HOLDOFF = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [15:0]             FILL_FULL = 16'(pREF_SAMPLES);
  localparam logic [15:0]             FILL_HALF = 16'(pREF_SAMPLES / 2);
  localparam logic [pCOUNT_WIDTH-1:0] COUNT_MAX = '1;

  // Saturating increment for the trigger counter: sticks at all-ones.
  function automatic logic [pCOUNT_WIDTH-1:0] sat_inc(
    input logic [pCOUNT_WIDTH-1:0] val
  );
    if (val == COUNT_MAX) return COUNT_MAX;
    else                  return val + 1'b1;
  endfunction

  // Last cnt value of the holdoff window; a holdoff of 0 behaves as 1.
  function automatic logic [15:0] holdoff_last(
    input logic [pHOLDOFF_WIDTH-1:0] ho
  );
    if (ho == '0) return 16'd0;
    else          return 16'(ho) - 16'd1;
  endfunction

  state_t                  r_state;
  logic [15:0]             r_cnt;
  logic [15:0]             r_fill_len;
  logic                    r_trigger;
  logic                    r_triggered;
  logic [pCOUNT_WIDTH-1:0] r_num_triggers;

  state_t                  w_state_nxt;
  logic [15:0]             w_cnt_nxt;
  logic [15:0]             w_fill_len_nxt;
  logic                    w_hit;
  logic [15:0]             w_holdoff_last;
  logic [pCOUNT_WIDTH-1:0] w_num_cleared;
  logic [pCOUNT_WIDTH-1:0] w_num_nxt;
  logic                    w_triggered_nxt;

  assign w_holdoff_last = holdoff_last(bus.holdoff);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state and sequencing decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_fill_len_nxt = r_fill_len;
    w_hit          = 1'b0;

    // Disarm overrides everything, including a match seen in ACTIVE, so a
    // coincident disarm never produces a trigger or bumps the count.
    if (!bus.armed_and_ready) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_state_nxt    = FILL;
          w_cnt_nxt      = 16'd0;
          w_fill_len_nxt = bus.short_sad ? FILL_HALF : FILL_FULL;
        end
        FILL: begin
          // Matches are meaningless until the reference buffer is full.
          w_cnt_nxt = r_cnt + 16'd1;
          if (r_cnt == r_fill_len - 16'd1) w_state_nxt = ACTIVE;
        end
        ACTIVE: begin
          if (bus.match_in) begin
            w_hit       = 1'b1;
            w_cnt_nxt   = 16'd0;
            w_state_nxt = bus.multiple_triggers ? HOLDOFF : DONE;
          end
        end
        HOLDOFF: begin
          w_cnt_nxt = r_cnt + 16'd1;
          if (r_cnt == w_holdoff_last) w_state_nxt = ACTIVE;
        end
        DONE: begin
          w_state_nxt = DONE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Status update: clear is applied first, then a coincident trigger counts,
  // so clear + trigger in one cycle leaves triggered=1, num_triggers=1.
  always_comb begin
    w_num_cleared   = bus.clear_status ? '0 : r_num_triggers;
    w_num_nxt       = w_hit ? sat_inc(w_num_cleared) : w_num_cleared;
    w_triggered_nxt = w_hit | (r_triggered & ~bus.clear_status);
  end

  // ---------------------------------------------------------------------------
  // Counter, fill length, trigger pulse and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt          <= 16'd0;
      r_fill_len     <= FILL_FULL;
      r_trigger      <= 1'b0;
      r_triggered    <= 1'b0;
      r_num_triggers <= '0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_fill_len     <= w_fill_len_nxt;
      r_trigger      <= w_hit;
      r_triggered    <= w_triggered_nxt;
      r_num_triggers <= w_num_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The datapath is flushed exactly while idle, so flush drops on the same
  // edge that leaves IDLE.
  assign bus.sad_flush    = (r_state == IDLE);
  assign bus.trigger      = r_trigger;
  assign bus.triggered    = r_triggered;
  assign bus.num_triggers = r_num_triggers;
  assign bus.state        = r_state;

endmodule

// File: tb/tb_sad_trigger_ctrl.sv
module tb_sad_trigger_ctrl;
  localparam int REF  = 128;
  localparam int CW   = 8;
  localparam int HW   = 16;
  localparam int CMAX = 255;

  logic clk = 1'b0;
  logic reset_n;

  sad_trigger_ctrl_if #(.pCOUNT_WIDTH(CW), .pHOLDOFF_WIDTH(HW)) bus ();

  sad_trigger_ctrl #(
    .pREF_SAMPLES  (REF),
    .pCOUNT_WIDTH  (CW),
    .pHOLDOFF_WIDTH(HW)
  ) dut (
    .clk_adc(clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  // Reference model: time-window view. An armed run has an "earliest edge
  // at which a match is honoured" (m_next_ok); triggers push it out by the
  // dead time; single mode sets m_done.
  int t;
  int m_next_ok;
  bit m_idle, m_done, m_from_arm;
  bit m_trig, m_triggered;
  int m_count;
  int m_state;

  task automatic model_reset();
    t = 0; m_next_ok = 0; m_idle = 1; m_done = 0; m_from_arm = 0;
    m_trig = 0; m_triggered = 0; m_count = 0; m_state = 0;
  endtask

  task automatic drive(input bit arm, input bit shrt, input bit multi,
                       input int ho, input bit clr, input bit match);
    @(negedge clk);
    bus.armed_and_ready   = arm;
    bus.short_sad         = shrt;
    bus.multiple_triggers = multi;
    bus.holdoff           = 16'(ho);
    bus.clear_status      = clr;
    bus.match_in          = match;
  endtask

  // Advance one edge and update the model from the inputs sampled there.
  task automatic tick();
    bit inc;
    int ho_eff;
    @(posedge clk);
    t++;
    inc    = 0;
    m_trig = 0;
    ho_eff = (bus.holdoff == 0) ? 1 : int'(bus.holdoff);
    if (!bus.armed_and_ready) begin
      m_idle = 1;
    end else if (m_idle) begin
      m_idle = 0; m_done = 0; m_from_arm = 1;
      m_next_ok = t + (bus.short_sad ? REF / 2 : REF) + 1;
    end else if (!m_done && t >= m_next_ok && bus.match_in) begin
      inc = 1; m_trig = 1;
      if (bus.multiple_triggers) begin
        m_next_ok = t + ho_eff + 1; m_from_arm = 0;
      end else begin
        m_done = 1;
      end
    end
    if (bus.clear_status) begin m_triggered = 0; m_count = 0; end
    if (inc) begin m_triggered = 1; if (m_count < CMAX) m_count++; end
    if (m_idle)                 m_state = 0;
    else if (m_done)            m_state = 4;
    else if (t < m_next_ok - 1) m_state = m_from_arm ? 1 : 3;
    else                        m_state = 2;
    #1;
  endtask

  task automatic do_clear();
    drive(0, 0, 0, 0, 1, 0);
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d expected 0", bus.state); end
    n_cmp++; if (bus.sad_flush !== 1'b1) begin n_bad++; $display("FAIL reset_flush got %0b expected 1", bus.sad_flush); end
    n_cmp++; if (bus.trigger !== 1'b0) begin n_bad++; $display("FAIL reset_trigger got %0b expected 0", bus.trigger); end
    n_cmp++; if (bus.triggered !== 1'b0) begin n_bad++; $display("FAIL reset_triggered got %0b expected 0", bus.triggered); end
    n_cmp++; if (bus.num_triggers !== 8'd0) begin n_bad++; $display("FAIL reset_count got %0d expected 0", bus.num_triggers); end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL post_reset_idle got %0d expected 0", bus.state); end
  endtask

  task automatic test_fill_long();
    int lat;
    bit found;
    lat = 0; found = 0;
    do_clear();
    drive(1, 0, 0, 0, 0, 1);
    tick();
    n_cmp++; if (bus.sad_flush !== 1'b0) begin n_bad++; $display("FAIL fill_long_flush_at_arm got %0b expected 0", bus.sad_flush); end
    n_cmp++; if (bus.state !== 3'd1) begin n_bad++; $display("FAIL fill_long_state_fill got %0d expected 1", bus.state); end
    for (int i = 1; i <= 200 && !found; i++) begin
      drive(1, 0, 0, 0, 0, 1);
      tick();
      n_cmp++; if (bus.trigger !== m_trig) begin n_bad++; $display("FAIL fill_long_trigger edge=%0d got %0b expected %0b", i, bus.trigger, m_trig); end
      n_cmp++; if (bus.sad_flush !== 1'b0) begin n_bad++; $display("FAIL fill_long_flush edge=%0d got %0b expected 0", i, bus.sad_flush); end
      if (bus.trigger === 1'b1) begin found = 1; lat = i; end
    end
    n_cmp++; if (!found || lat != REF + 1) begin n_bad++; $display("FAIL fill_long_latency got %0d expected %0d", lat, REF + 1); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_fill_short();
    int lat, seen;
    bit found;
    lat = 0; found = 0; seen = 0;
    do_clear();
    drive(1, 1, 0, 0, 0, 1);
    tick();
    for (int i = 1; i <= 200 && !found; i++) begin
      drive(1, 1, 0, 0, 0, 1);
      tick();
      n_cmp++; if (bus.trigger !== m_trig) begin n_bad++; $display("FAIL fill_short_trigger edge=%0d got %0b expected %0b", i, bus.trigger, m_trig); end
      if (bus.trigger === 1'b1) begin found = 1; lat = i; end
    end
    n_cmp++; if (!found || lat != REF / 2 + 1) begin n_bad++; $display("FAIL fill_short_latency got %0d expected %0d", lat, REF / 2 + 1); end
    // Re-arm and pulse match only while the reference is still filling.
    drive(0, 1, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0);
    tick();
    for (int i = 1; i <= REF / 2; i++) begin
      drive(1, 1, 0, 0, 0, (i % 2) == 1);
      tick();
      if (bus.trigger === 1'b1) seen++;
    end
    repeat (10) begin
      drive(1, 1, 0, 0, 0, 0);
      tick();
      if (bus.trigger === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL fill_short_match_in_fill got %0d triggers expected 0", seen); end
    n_cmp++; if (bus.num_triggers !== 8'd1) begin n_bad++; $display("FAIL fill_short_count got %0d expected 1", bus.num_triggers); end
    n_cmp++; if (bus.state !== 3'd2) begin n_bad++; $display("FAIL fill_short_state got %0d expected 2", bus.state); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_multi_holdoff();
    int tr[3];
    int ntr;
    tr = '{0, 0, 0}; ntr = 0;
    do_clear();
    drive(1, 0, 1, 10, 0, 1);
    tick();
    for (int i = 0; i < 500 && ntr < 3; i++) begin
      drive(1, 0, 1, 10, 0, 1);
      tick();
      n_cmp++; if (bus.trigger !== m_trig) begin n_bad++; $display("FAIL multi_trigger t=%0d got %0b expected %0b", t, bus.trigger, m_trig); end
      if (bus.trigger === 1'b1) begin tr[ntr] = t; ntr++; end
    end
    n_cmp++; if (ntr != 3) begin n_bad++; $display("FAIL multi_trigger_count got %0d expected 3", ntr); end
    n_cmp++; if (tr[1] - tr[0] != 11) begin n_bad++; $display("FAIL multi_interval1 got %0d expected 11", tr[1] - tr[0]); end
    n_cmp++; if (tr[2] - tr[1] != 11) begin n_bad++; $display("FAIL multi_interval2 got %0d expected 11", tr[2] - tr[1]); end
    drive(0, 0, 1, 10, 0, 1);
    tick();
    n_cmp++; if (bus.num_triggers !== 8'd3) begin n_bad++; $display("FAIL multi_disarm_count got %0d expected 3", bus.num_triggers); end
    n_cmp++; if (bus.triggered !== 1'b1) begin n_bad++; $display("FAIL multi_disarm_triggered got %0b expected 1", bus.triggered); end
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL multi_disarm_state got %0d expected 0", bus.state); end
    n_cmp++; if (bus.sad_flush !== 1'b1) begin n_bad++; $display("FAIL multi_disarm_flush got %0b expected 1", bus.sad_flush); end
  endtask

  task automatic test_single();
    int seen;
    seen = 0;
    do_clear();
    drive(1, 0, 0, 5, 0, 0);
    tick();
    repeat (REF) begin
      drive(1, 0, 0, 5, 0, 0);
      tick();
    end
    n_cmp++; if (bus.state !== 3'd2) begin n_bad++; $display("FAIL single_active got %0d expected 2", bus.state); end
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 0, 5, 0, 1); tick(); if (bus.trigger === 1'b1) seen++;
      drive(1, 0, 0, 5, 0, 0); tick(); if (bus.trigger === 1'b1) seen++;
      drive(1, 0, 0, 5, 0, 0); tick(); if (bus.trigger === 1'b1) seen++;
    end
    n_cmp++; if (seen != 1) begin n_bad++; $display("FAIL single_triggers got %0d expected 1", seen); end
    n_cmp++; if (bus.state !== 3'd4) begin n_bad++; $display("FAIL single_done got %0d expected 4", bus.state); end
    n_cmp++; if (bus.num_triggers !== 8'd1) begin n_bad++; $display("FAIL single_count got %0d expected 1", bus.num_triggers); end
    drive(0, 0, 0, 5, 0, 0);
    tick();
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL single_disarm got %0d expected 0", bus.state); end
  endtask

  task automatic test_saturation();
    int ntr, last;
    ntr = 0; last = 0;
    do_clear();
    drive(1, 0, 1, 0, 0, 1);
    tick();
    for (int i = 0; i < 1000 && ntr < 300; i++) begin
      drive(1, 0, 1, 0, 0, 1);
      tick();
      n_cmp++; if (bus.trigger !== m_trig) begin n_bad++; $display("FAIL sat_trigger t=%0d got %0b expected %0b", t, bus.trigger, m_trig); end
      if (bus.trigger === 1'b1) begin
        if (ntr > 0) begin
          n_cmp++; if (t - last != 2) begin n_bad++; $display("FAIL sat_interval got %0d expected 2", t - last); end
        end
        last = t; ntr++;
      end
    end
    n_cmp++; if (ntr != 300) begin n_bad++; $display("FAIL sat_trigger_count got %0d expected 300", ntr); end
    n_cmp++; if (bus.num_triggers !== 8'(CMAX)) begin n_bad++; $display("FAIL sat_count got %0d expected %0d", bus.num_triggers, CMAX); end
    n_cmp++; if (bus.triggered !== 1'b1) begin n_bad++; $display("FAIL sat_triggered got %0b expected 1", bus.triggered); end
    drive(1, 0, 1, 0, 0, 1);
    tick();
    drive(1, 0, 1, 0, 1, 1);
    tick();
    n_cmp++; if (bus.trigger !== 1'b1) begin n_bad++; $display("FAIL clear_coincident_trigger got %0b expected 1", bus.trigger); end
    n_cmp++; if (bus.num_triggers !== 8'd1) begin n_bad++; $display("FAIL clear_coincident_count got %0d expected 1", bus.num_triggers); end
    n_cmp++; if (bus.triggered !== 1'b1) begin n_bad++; $display("FAIL clear_coincident_triggered got %0b expected 1", bus.triggered); end
    drive(1, 0, 1, 0, 1, 1);
    tick();
    n_cmp++; if (bus.num_triggers !== 8'd0) begin n_bad++; $display("FAIL clear_alone_count got %0d expected 0", bus.num_triggers); end
    n_cmp++; if (bus.triggered !== 1'b0) begin n_bad++; $display("FAIL clear_alone_triggered got %0b expected 0", bus.triggered); end
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_reset_mid();
    bit reached;
    reached = 0;
    drive(1, 0, 1, 10, 0, 1);
    tick();
    for (int i = 0; i < 300 && !reached; i++) begin
      drive(1, 0, 1, 10, 0, 1);
      tick();
      if (bus.state === 3'd3) reached = 1;
    end
    n_cmp++; if (!reached) begin n_bad++; $display("FAIL reset_mid_reach_holdoff got 0 expected 1"); end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL reset_mid_state got %0d expected 0", bus.state); end
    n_cmp++; if (bus.sad_flush !== 1'b1) begin n_bad++; $display("FAIL reset_mid_flush got %0b expected 1", bus.sad_flush); end
    n_cmp++; if (bus.trigger !== 1'b0) begin n_bad++; $display("FAIL reset_mid_trigger got %0b expected 0", bus.trigger); end
    n_cmp++; if (bus.triggered !== 1'b0) begin n_bad++; $display("FAIL reset_mid_triggered got %0b expected 0", bus.triggered); end
    n_cmp++; if (bus.num_triggers !== 8'd0) begin n_bad++; $display("FAIL reset_mid_count got %0d expected 0", bus.num_triggers); end
    @(negedge clk);
    reset_n = 1'b1;
    bus.armed_and_ready = 1'b0;
    bus.match_in = 1'b0;
    tick();
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL reset_mid_release got %0d expected 0", bus.state); end
  endtask

  task automatic test_disarm_match();
    do_clear();
    drive(1, 0, 1, 3, 0, 0);
    tick();
    repeat (REF) begin
      drive(1, 0, 1, 3, 0, 0);
      tick();
    end
    drive(1, 0, 1, 3, 0, 1);
    tick();
    n_cmp++; if (bus.trigger !== 1'b1) begin n_bad++; $display("FAIL disarm_first_trigger got %0b expected 1", bus.trigger); end
    repeat (4) begin
      drive(1, 0, 1, 3, 0, 0);
      tick();
    end
    n_cmp++; if (bus.state !== 3'd2) begin n_bad++; $display("FAIL disarm_back_active got %0d expected 2", bus.state); end
    drive(0, 0, 1, 3, 0, 1);
    tick();
    n_cmp++; if (bus.trigger !== 1'b0) begin n_bad++; $display("FAIL disarm_match_trigger got %0b expected 0", bus.trigger); end
    n_cmp++; if (bus.num_triggers !== 8'd1) begin n_bad++; $display("FAIL disarm_match_count got %0d expected 1", bus.num_triggers); end
    n_cmp++; if (bus.state !== 3'd0) begin n_bad++; $display("FAIL disarm_match_state got %0d expected 0", bus.state); end
  endtask

  task automatic test_random();
    bit arm, shrt, multi, clr, match;
    int ho;
    arm = 0; shrt = 0; multi = 1; ho = 2;
    for (int i = 0; i < 4000; i++) begin
      if (!arm) begin
        shrt  = ($urandom_range(0, 1) == 1);
        multi = ($urandom_range(0, 3) != 0);
        ho    = $urandom_range(0, 6);
        arm   = ($urandom_range(0, 2) == 0);
      end else begin
        arm = ($urandom_range(0, 399) != 0);
      end
      match = ($urandom_range(0, 2) == 0);
      clr   = ($urandom_range(0, 49) == 0);
      drive(arm, shrt, multi, ho, clr, match);
      tick();
      n_cmp++; if (bus.trigger !== m_trig) begin n_bad++; $display("FAIL rand_trigger t=%0d got %0b expected %0b", t, bus.trigger, m_trig); end
      n_cmp++; if (bus.state !== 3'(m_state)) begin n_bad++; $display("FAIL rand_state t=%0d got %0d expected %0d", t, bus.state, m_state); end
      n_cmp++; if (bus.sad_flush !== m_idle) begin n_bad++; $display("FAIL rand_flush t=%0d got %0b expected %0b", t, bus.sad_flush, m_idle); end
      n_cmp++; if (bus.triggered !== m_triggered) begin n_bad++; $display("FAIL rand_triggered t=%0d got %0b expected %0b", t, bus.triggered, m_triggered); end
      n_cmp++; if (bus.num_triggers !== 8'(m_count)) begin n_bad++; $display("FAIL rand_count t=%0d got %0d expected %0d", t, bus.num_triggers, m_count); end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset_n = 1'b0;
    bus.armed_and_ready = 1'b0; bus.short_sad = 1'b0; bus.multiple_triggers = 1'b0;
    bus.holdoff = '0; bus.clear_status = 1'b0; bus.match_in = 1'b0;
    model_reset();
    test_reset();
    test_fill_long();
    test_fill_short();
    test_multi_holdoff();
    test_single();
    test_saturation();
    test_reset_mid();
    test_disarm_match();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
